// File: rtl/crc16_frame_checker_if.sv
// crc16_frame_checker_if: serial frame input and check-result bus of the CRC16 frame checker.
interface crc16_frame_checker_if;
  logic start_i;
  logic data_valid_i;
  logic data_i;
  logic busy_o;
  logic done_o;
  logic crc_ok_o;
  logic [15:0] calc_crc_o;
  logic [15:0] rx_crc_o;
  modport master(
    output start_i, data_valid_i, data_i,
    input busy_o, done_o, crc_ok_o, calc_crc_o, rx_crc_o
  );
  modport slave(
    input start_i, data_valid_i, data_i,
    output busy_o, done_o, crc_ok_o, calc_crc_o, rx_crc_o
  );
endinterface

// File: rtl/crc16_frame_checker.sv
// crc16_frame_checker: serial MSB-first CRC16 check of a payload followed by its 16-bit CRC.
module crc16_frame_checker #(
  parameter int unsigned PAYLOAD_BITS = 144,
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'h0000
) (
  input logic clk_i,
  input logic rstn_i,
  crc16_frame_checker_if.slave bus
);
  localparam int CW = $clog2((PAYLOAD_BITS > 16 ? PAYLOAD_BITS : 16) + 1);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [15:0] crc, crc_upd, calc_crc, rx_crc;
  logic take, last_pay, last_chk, fin, done, ok;
  assign take = bus.data_valid_i && !bus.start_i && state != IDLE;
  assign crc_upd = {crc[14:0], 1'b0} ^ ((crc[15] ^ bus.data_i) ? POLY : 16'h0000);
  assign last_pay = state == PAYLOAD && cnt == CW'(PAYLOAD_BITS - 1);
  assign last_chk = state == CHECK && cnt == CW'(15);
  always_comb begin
    state_nxt = bus.start_i ? PAYLOAD : !take ? state : last_pay ? CHECK : last_chk ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else state <= state_nxt;
  end
  // fin marks the last CRC bit; the verdict is registered from the final crc one cycle later
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      crc <= INIT;
      cnt <= '0;
      calc_crc <= 16'h0000;
      rx_crc <= 16'h0000;
      fin <= 1'b0;
      done <= 1'b0;
      ok <= 1'b0;
    end else begin
      fin <= take && last_chk;
      done <= fin;
      ok <= bus.start_i ? 1'b0 : fin ? crc == 16'h0000 : ok;
      if (bus.start_i) begin
        crc <= INIT;
        cnt <= '0;
        rx_crc <= 16'h0000;
      end else if (take) begin
        crc <= crc_upd;
        cnt <= (last_pay || last_chk) ? '0 : cnt + 1'b1;
        if (last_pay) calc_crc <= crc_upd;
        if (state == CHECK) rx_crc <= {rx_crc[14:0], bus.data_i};
      end
    end
  end
  assign bus.busy_o = state != IDLE;
  assign bus.done_o = done;
  assign bus.crc_ok_o = ok;
  assign bus.calc_crc_o = calc_crc;
  assign bus.rx_crc_o = rx_crc;
endmodule

// File: tb/tb_crc16_frame_checker.sv
// tb_crc16_frame_checker: directed frames against the 144-bit and 8-bit CRC16 frame checkers.
module tb_crc16_frame_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  crc16_frame_checker_if f();
  crc16_frame_checker_if g();
  crc16_frame_checker dut (.clk_i(clk), .rstn_i(rst_n), .bus(f.slave));
  crc16_frame_checker #(.PAYLOAD_BITS(8)) dut8 (.clk_i(clk), .rstn_i(rst_n), .bus(g.slave));
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nd = 0;
  int nd8 = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (f.done_o) begin
      nd <= nd + 1;
      done_cyc <= cyc;
    end
    if (g.done_o) nd8 <= nd8 + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] crc_of(input logic [143:0] p, input int flip);
    logic [15:0] r;
    logic b;
    r = 16'h0000;
    for (int i = 143; i >= 0; i--) begin
      b = p[i] ^ (i == flip);
      r = {r[14:0], 1'b0} ^ ((r[15] ^ b) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction
  // start is driven together with valid/data=1 so that a consumed start-cycle bit would corrupt the frame
  task automatic frame(input logic [143:0] p, input logic [15:0] c, input int flip,
                       input int idle_pct, input int len, output int idles);
    idles = 0;
    @(negedge clk);
    f.start_i = 1'b1;
    f.data_valid_i = 1'b1;
    f.data_i = 1'b1;
    @(negedge clk);
    f.start_i = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(99) < idle_pct) begin
        f.data_valid_i = 1'b0;
        f.data_i = 1'($urandom);
        idles++;
        @(negedge clk);
      end
      f.data_valid_i = 1'b1;
      f.data_i = i < 144 ? p[143-i] ^ ((143 - i) == flip) : c[159-i];
      @(negedge clk);
    end
    f.data_valid_i = 1'b0;
  endtask
  logic [143:0] pay;
  logic [15:0] good;
  logic [23:0] w8;
  int idl, n0;
  initial begin
    f.start_i = 1'b0;
    f.data_valid_i = 1'b0;
    f.data_i = 1'b0;
    g.start_i = 1'b0;
    g.data_valid_i = 1'b0;
    g.data_i = 1'b0;
    pay = 144'hA5C3_1F70_9E2B_D846_03FC_5A17_E9B4_6D2C_81F5;
    good = crc_of(pay, -1);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(f.busy_o), 0);
    check("rst_done", 32'(f.done_o), 0);
    check("rst_ok", 32'(f.crc_ok_o), 0);
    check("rst_calc", 32'(f.calc_crc_o), 0);
    check("rst_rx", 32'(f.rx_crc_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(f.busy_o), 0);
    n0 = nd;
    frame(pay, good, -1, 0, 160, idl);
    repeat (4) @(negedge clk);
    check("good_done", 32'(nd - n0), 1);
    check("good_lat", 32'(done_cyc - start_cyc), 161);
    check("good_ok", 32'(f.crc_ok_o), 1);
    check("good_calc", 32'(f.calc_crc_o), 32'(good));
    check("good_rx", 32'(f.rx_crc_o), 32'(good));
    check("good_busy", 32'(f.busy_o), 0);
    n0 = nd;
    frame(pay, good, 70, 0, 160, idl);
    repeat (4) @(negedge clk);
    check("flip_done", 32'(nd - n0), 1);
    check("flip_ok", 32'(f.crc_ok_o), 0);
    check("flip_calc", 32'(f.calc_crc_o), 32'(crc_of(pay, 70)));
    check("flip_differs", 32'(f.calc_crc_o != good), 1);
    n0 = nd;
    frame(pay, good, -1, 30, 160, idl);
    repeat (4) @(negedge clk);
    check("gap_done", 32'(nd - n0), 1);
    check("gap_lat", 32'(done_cyc - start_cyc), 32'(161 + idl));
    check("gap_ok", 32'(f.crc_ok_o), 1);
    check("gap_rx", 32'(f.rx_crc_o), 32'(good));
    n0 = nd;
    frame(pay, good, 5, 0, 50, idl);
    check("abort_busy", 32'(f.busy_o), 1);
    check("abort_ok_clr", 32'(f.crc_ok_o), 0);
    check("abort_calc_hold", 32'(f.calc_crc_o), 32'(good));
    frame(pay, good, -1, 0, 160, idl);
    repeat (4) @(negedge clk);
    check("abort_one_done", 32'(nd - n0), 1);
    check("abort_ok", 32'(f.crc_ok_o), 1);
    check("abort_lat", 32'(done_cyc - start_cyc), 161);
    n0 = nd;
    frame(pay, good, -1, 0, 150, idl);
    check("chk_busy", 32'(f.busy_o), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(f.busy_o), 0);
    check("mid_rst_ok", 32'(f.crc_ok_o), 0);
    check("mid_rst_calc", 32'(f.calc_crc_o), 0);
    check("mid_rst_rx", 32'(f.rx_crc_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", 32'(nd - n0), 0);
    frame(pay, good, -1, 0, 160, idl);
    repeat (4) @(negedge clk);
    check("post_rst_done", 32'(nd - n0), 1);
    check("post_rst_ok", 32'(f.crc_ok_o), 1);
    check("post_rst_calc", 32'(f.calc_crc_o), 32'(good));
    w8 = 24'h31_2672;
    n0 = nd8;
    @(negedge clk);
    g.start_i = 1'b1;
    @(negedge clk);
    g.start_i = 1'b0;
    for (int i = 0; i < 24; i++) begin
      g.data_valid_i = 1'b1;
      g.data_i = w8[23-i];
      @(negedge clk);
    end
    g.data_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("x8_calc", 32'(g.calc_crc_o), 32'h2672);
    check("x8_rx", 32'(g.rx_crc_o), 32'h2672);
    check("x8_ok", 32'(g.crc_ok_o), 1);
    check("x8_done", 32'(nd8 - n0), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
